// File: rtl/fir_mc_if.sv
// fir_mc_if: sample input, coefficient write port and result output of fir_mc.
// The slave modport is the filter's view; the master modport drives it.
interface fir_mc_if #(
    parameter int TAPS        = 8,
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int OUT_WIDTH   = 16
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int AW = TAPS > 1 ? $clog2(TAPS) : 1;
    logic signed [DATA_WIDTH-1:0]  in_sample;
    logic [CW-1:0]                 in_channel;
    logic                          in_valid;
    logic                          in_ready;
    logic                          coef_wr_en;
    logic [AW-1:0]                 coef_wr_addr;
    logic signed [COEFF_WIDTH-1:0] coef_wr_data;
    logic signed [OUT_WIDTH-1:0]   out_sample;
    logic [CW-1:0]                 out_channel;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_sat;
    modport master (
        output in_sample, in_channel, in_valid, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
        input  in_ready, out_sample, out_channel, out_valid, out_sat
    );
    modport slave (
        input  in_sample, in_channel, in_valid, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
        output in_ready, out_sample, out_channel, out_valid, out_sat
    );
endinterface

// File: rtl/fir_mc.sv
// fir_mc: time-multiplexed multi-channel FIR, one tap per cycle through a shared
// multiplier, followed by a round/saturate stage and a ready/valid output.
module fir_mc #(
    parameter int TAPS        = 8,
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int SHIFT       = 15,
    parameter int OUT_WIDTH   = 16
) (
    input logic     clk,
    input logic     rst,
    fir_mc_if.slave bus
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int AW = TAPS > 1 ? $clog2(TAPS) : 1;
    localparam int TW = $clog2(TAPS + 1);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [TW-1:0] LAST = TW'(TAPS);
    localparam logic [CW:0] NCH = (CW + 1)'(CHANNELS);
    localparam logic [AW:0] NTAP = (AW + 1)'(TAPS);
    localparam logic signed [ACC_WIDTH-1:0] RND = (ACC_WIDTH'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH-1:0] OMAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                        state_q;
    logic [TW-1:0]                 tap_q;
    logic [CW-1:0]                 ch_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [DATA_WIDTH-1:0]  x_q [CHANNELS][TAPS];
    logic signed [COEFF_WIDTH-1:0] c_q [TAPS];
    logic signed [OUT_WIDTH-1:0]   out_sample_q;
    logic [CW-1:0]                 out_channel_q;
    logic                          out_valid_q;
    logic                          out_sat_q;

    logic [AW-1:0]                 tap_idx;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic signed [ACC_WIDTH-1:0]   r_d;
    logic                          sat_hi, sat_lo, accept, ch_ok, addr_ok;

    assign tap_idx = tap_q[AW-1:0];
    assign prod    = x_q[ch_q][tap_idx] * c_q[tap_idx];
    assign acc_d   = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign r_d     = (acc_q + RND) >>> SHIFT;
    assign sat_hi  = r_d > OMAX;
    assign sat_lo  = r_d < OMIN;
    assign ch_ok   = {1'b0, bus.in_channel} < NCH;
    assign addr_ok = {1'b0, bus.coef_wr_addr} < NTAP;
    assign accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready    = (state_q == IDLE) && !bus.coef_wr_en;
    assign bus.out_sample  = out_sample_q;
    assign bus.out_channel = out_channel_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sat     = out_sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tap_q         <= '0;
            ch_q          <= '0;
            acc_q         <= '0;
            out_sample_q  <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            out_sat_q     <= 1'b0;
            for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < TAPS; k++) x_q[c][k] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.coef_wr_en && addr_ok) c_q[bus.coef_wr_addr] <= bus.coef_wr_data;
                    // out-of-range channels complete the handshake but leave everything untouched
                    if (accept && ch_ok) begin
                        for (int c = 0; c < CHANNELS; c++)
                            if (CW'(c) == bus.in_channel) begin
                                for (int k = TAPS - 1; k > 0; k--) x_q[c][k] <= x_q[c][k-1];
                                x_q[c][0] <= bus.in_sample;
                            end
                        ch_q    <= bus.in_channel;
                        tap_q   <= '0;
                        acc_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (tap_q != LAST) begin
                        acc_q <= acc_d;
                        tap_q <= tap_q + 1'b1;
                    end else begin
                        out_sample_q  <= sat_hi ? OMAX[OUT_WIDTH-1:0] : sat_lo ? OMIN[OUT_WIDTH-1:0] : r_d[OUT_WIDTH-1:0];
                        out_sat_q     <= sat_hi || sat_lo;
                        out_channel_q <= ch_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
